// File: rtl/cpu_pkg.sv
// Shared core definitions for the issue path: opcodes, issue classes and
// issue FSM state codes.
package cpu_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_CALCIMM = 7'b0010011;
  localparam logic [6:0] OP_CALC    = 7'b0110011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;

  typedef enum logic [1:0] {ALU, LSU, BR} issue_class_e;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;

  // Unknown opcodes fall through to the ALU class on purpose.
  function automatic issue_class_e opcode_class(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE:          return LSU;
      OP_JAL, OP_JALR, OP_BRANCH: return BR;
      default:                    return ALU;
    endcase
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Free-slot credit counter: starts full, +1 per release, -1 per consume,
// sticky error when a release arrives while already full.
module credit_counter #(
  parameter int SLOTS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic credit_return,
  input  logic consume,
  input  logic flush,
  output logic nonzero,
  output logic error
);

  localparam int CW = $clog2(SLOTS + 1);
  localparam logic [CW-1:0] FULL = CW'(SLOTS);

  logic [CW-1:0] count_reg;

  // Error survives flush; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= FULL;
      error     <= 1'b0;
    end else if (flush) begin
      count_reg <= FULL;
    end else if (credit_return && !consume) begin
      if (count_reg == FULL) error <= 1'b1;
      else                   count_reg <= count_reg + 1'b1;
    end else if (consume && !credit_return) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign nonzero = (count_reg != '0);

endmodule

// File: rtl/issue_controller.sv
// Issue sequencer between fetch and decode: instruction FIFO, ROB/RS credit
// tracking and a SETUP/PULSE handshake toward the decoder.
module issue_controller
  import cpu_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int ROB_SLOTS   = 8,
  parameter int ALU_SLOTS   = 4,
  parameter int LSU_SLOTS   = 4,
  parameter int BR_SLOTS    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchValid,
  input  logic [31:0] fetchInstr,
  input  logic [31:0] fetchPC,
  output logic        fetchReady,
  output logic [31:0] decodeInstr,
  output logic [31:0] decodePC,
  output logic        available,
  output logic        decodePulse,
  input  logic        robRelease,
  input  logic        aluRelease,
  input  logic        lsuRelease,
  input  logic        brRelease,
  input  logic        flush,
  output logic        stall,
  output logic        creditError
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(QUEUE_DEPTH);

  logic [31:0]   instr_mem [QUEUE_DEPTH];
  logic [31:0]   pc_mem    [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [1:0]    state_reg, state_next;

  logic          push, issue, eligible, class_ok;
  logic          rob_ok, alu_ok, lsu_ok, br_ok;
  logic [3:0]    err;
  logic [31:0]   head_instr, head_pc;
  issue_class_e  head_class;

  assign fetchReady = (count_reg != FULL_COUNT);
  assign push       = fetchValid && fetchReady && !flush;
  assign head_instr = instr_mem[rd_ptr_reg];
  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_class = opcode_class(head_instr[6:0]);

  always_comb begin
    class_ok = alu_ok;
    case (head_class)
      LSU:     class_ok = lsu_ok;
      BR:      class_ok = br_ok;
      default: class_ok = alu_ok;
    endcase
  end

  assign eligible = (count_reg != '0) && rob_ok && class_ok;
  assign issue    = !flush && eligible && (state_reg == IDLE || state_reg == PULSE);
  assign stall    = (count_reg != '0) && !eligible && (state_reg == IDLE);
  assign creditError = |err;

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= fetchInstr;
      pc_mem[wr_ptr_reg]    <= fetchPC;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !issue)      count_reg <= count_reg + 1'b1;
      else if (issue && !push) count_reg <= count_reg - 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (eligible) state_next = SETUP;
      SETUP:   state_next = PULSE;
      PULSE:   state_next = eligible ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      decodeInstr <= '0;
      decodePC    <= '0;
      available   <= 1'b0;
      decodePulse <= 1'b0;
    end else begin
      state_reg   <= state_next;
      decodePulse <= !flush && (state_reg == SETUP);
      if (flush) begin
        available <= 1'b0;
      end else if (issue) begin
        available   <= 1'b1;
        decodeInstr <= head_instr;
        decodePC    <= head_pc;
      end else if (state_reg == PULSE) begin
        available <= 1'b0;
      end
    end
  end

  credit_counter #(.SLOTS(ROB_SLOTS)) u_rob (
    .clock(clock), .reset(reset), .credit_return(robRelease), .consume(issue),
    .flush(flush), .nonzero(rob_ok), .error(err[0])
  );
  credit_counter #(.SLOTS(ALU_SLOTS)) u_alu (
    .clock(clock), .reset(reset), .credit_return(aluRelease),
    .consume(issue && head_class == ALU), .flush(flush), .nonzero(alu_ok), .error(err[1])
  );
  credit_counter #(.SLOTS(LSU_SLOTS)) u_lsu (
    .clock(clock), .reset(reset), .credit_return(lsuRelease),
    .consume(issue && head_class == LSU), .flush(flush), .nonzero(lsu_ok), .error(err[2])
  );
  credit_counter #(.SLOTS(BR_SLOTS)) u_br (
    .clock(clock), .reset(reset), .credit_return(brRelease),
    .consume(issue && head_class == BR), .flush(flush), .nonzero(br_ok), .error(err[3])
  );

endmodule

// File: tb/tb_issue_controller.sv
// Scoreboard bench for issue_controller: in-order expected queue, per-class
// outstanding-credit model, directed scenarios then randomized traffic.
module tb_issue_controller;

  localparam int QD = 4, ROB = 8, ALUS = 4, LSUS = 4, BRS = 2;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h0000a083;
  localparam logic [31:0] JAL  = 32'h0000006f;
  localparam logic [31:0] BEQ  = 32'h00000063;

  logic        clock = 1'b0, reset = 1'b1;
  logic        fetchValid = 1'b0;
  logic [31:0] fetchInstr = '0, fetchPC = '0;
  logic        robRelease = 1'b0, aluRelease = 1'b0, lsuRelease = 1'b0, brRelease = 1'b0;
  logic        flush = 1'b0;
  logic        fetchReady, available, decodePulse, stall, creditError;
  logic [31:0] decodeInstr, decodePC;

  issue_controller #(
    .QUEUE_DEPTH(QD), .ROB_SLOTS(ROB), .ALU_SLOTS(ALUS), .LSU_SLOTS(LSUS), .BR_SLOTS(BRS)
  ) dut (
    .clock(clock), .reset(reset), .fetchValid(fetchValid), .fetchInstr(fetchInstr),
    .fetchPC(fetchPC), .fetchReady(fetchReady), .decodeInstr(decodeInstr),
    .decodePC(decodePC), .available(available), .decodePulse(decodePulse),
    .robRelease(robRelease), .aluRelease(aluRelease), .lsuRelease(lsuRelease),
    .brRelease(brRelease), .flush(flush), .stall(stall), .creditError(creditError)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  logic [63:0] exp_q[$];
  int outst[3];
  int rob_out = 0;
  int pulses = 0, last_pulse_cyc = -1;
  int push_cyc = 0, rel_cyc = 0;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Issue class from the opcode field: loads/stores, control flow, else ALU.
  function automatic int cls_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h23:        return 1;
      7'h6f, 7'h67, 7'h63: return 2;
      default:             return 0;
    endcase
  endfunction

  function automatic int slots_of(input int c);
    return (c == 0) ? ALUS : (c == 1) ? LSUS : BRS;
  endfunction

  // Monitor: every decode strobe must deliver the oldest outstanding fetch,
  // with available high and without exceeding any credit budget.
  always @(negedge clock) begin
    logic [63:0] want;
    int c;
    if (!reset && decodePulse) begin
      pulses++;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_pulse: got instr %h pc %h, expected no pulse", decodeInstr, decodePC);
      end else begin
        want = exp_q.pop_front();
        chk("decode_data", {decodeInstr, decodePC}, want);
      end
      chk("available_at_pulse", 64'(available), 64'(1));
      c = cls_of(decodeInstr);
      outst[c]++;
      rob_out++;
      chk("class_credit_bound", 64'(outst[c] <= slots_of(c)), 64'(1));
      chk("rob_credit_bound", 64'(rob_out <= ROB), 64'(1));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    outst[0] = 0; outst[1] = 0; outst[2] = 0;
    rob_out = 0;
  endtask

  task automatic push(input logic [31:0] ins);
    int g = 0;
    while (!fetchReady && g < 200) begin tick(); g++; end
    if (!fetchReady) chk("push_ready_wait", 64'(fetchReady), 64'(1));
    fetchValid = 1'b1; fetchInstr = ins; fetchPC = pc_ctr;
    if (fetchReady) exp_q.push_back({ins, pc_ctr});
    push_cyc = cyc;
    pc_ctr += 4;
    tick();
    fetchValid = 1'b0;
  endtask

  task automatic rel(input bit r, input bit a, input bit l, input bit b);
    robRelease = r; aluRelease = a; lsuRelease = l; brRelease = b;
    if (r) rob_out--;
    if (a) outst[0]--;
    if (l) outst[1]--;
    if (b) outst[2]--;
    rel_cyc = cyc;
    tick();
    robRelease = 1'b0; aluRelease = 1'b0; lsuRelease = 1'b0; brRelease = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_model();
  endtask

  task automatic wait_pulse(input int target);
    int g = 0;
    while (pulses < target && g < 50) begin tick(); g++; end
    if (pulses < target) chk("pulse_wait", 64'(pulses), 64'(target));
  endtask

  // Hand back every credit the model holds until all fetched work has issued.
  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || rob_out != 0 || outst[0] != 0 || outst[1] != 0 || outst[2] != 0)
           && g < 1000) begin
      rel(rob_out > 0, outst[0] > 0, outst[1] > 0, outst[2] > 0);
      g++;
    end
    chk("drain_complete", 64'(exp_q.size() + rob_out + outst[0] + outst[1] + outst[2]), 64'(0));
    repeat (3) tick();
  endtask

  task automatic make_rob_empty();
    for (int i = 0; i < ROB; i++) begin
      int p0 = pulses;
      push(ADDI);
      wait_pulse(p0 + 1);
      rel(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fetchReady"}, 64'(fetchReady), 64'(1));
    chk({tag, "_decodeInstr"}, 64'(decodeInstr), 64'(0));
    chk({tag, "_decodePC"}, 64'(decodePC), 64'(0));
    chk({tag, "_available"}, 64'(available), 64'(0));
    chk({tag, "_decodePulse"}, 64'(decodePulse), 64'(0));
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_creditError"}, 64'(creditError), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish within time budget");
    $fatal(1);
  end

  initial begin
    int p0, p1, n_a;
    logic [6:0] ops [11];
    ops = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h0f, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63, 7'h7f};
    clear_model();

    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Single ADDI: strobe exactly once, three cycles after the push.
    p0 = pulses;
    push(ADDI);
    repeat (8) tick();
    chk("addi_pulse_count", 64'(pulses - p0), 64'(1));
    chk("addi_pulse_latency", 64'(last_pulse_cyc), 64'(push_cyc + 3));
    chk("addi_decodeInstr_held", 64'(decodeInstr), 64'(ADDI));
    chk("addi_available_after", 64'(available), 64'(0));
    drain();

    // Five loads against four LSU slots.
    p0 = pulses;
    for (int i = 0; i < 5; i++) push(LW);
    repeat (20) tick();
    chk("lsu_pulse_count", 64'(pulses - p0), 64'(4));
    chk("lsu_stall", 64'(stall), 64'(1));
    rel(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) tick();
    chk("lsu_fifth_count", 64'(pulses - p0), 64'(5));
    chk("lsu_fifth_latency", 64'(last_pulse_cyc), 64'(rel_cyc + 3));
    chk("lsu_stall_cleared", 64'(stall), 64'(0));
    drain();

    // FIFO full while ROB is exhausted; one ROB release lets exactly one go.
    make_rob_empty();
    p0 = pulses;
    for (int i = 0; i < QD; i++) push(ADDI);
    repeat (3) tick();
    chk("full_fetchReady", 64'(fetchReady), 64'(0));
    chk("full_stall", 64'(stall), 64'(1));
    chk("full_no_issue", 64'(pulses - p0), 64'(0));
    rel(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    chk("rob_release_one_issue", 64'(pulses - p0), 64'(1));
    chk("rob_release_fetchReady", 64'(fetchReady), 64'(1));
    drain();

    // ALU release coinciding with an ALU issue leaves the credit unchanged.
    p0 = pulses;
    for (int i = 0; i < 3; i++) push(ADDI);
    wait_pulse(p0 + 3);
    repeat (3) tick();
    p0 = pulses;
    fetchValid = 1'b1; fetchInstr = ADDI; fetchPC = pc_ctr;
    exp_q.push_back({ADDI, pc_ctr}); pc_ctr += 4; n_a = cyc;
    tick();
    fetchInstr = ADDI | 32'h00100000; fetchPC = pc_ctr;
    exp_q.push_back({ADDI | 32'h00100000, pc_ctr}); pc_ctr += 4;
    aluRelease = 1'b1; outst[0]--;
    tick();
    fetchValid = 1'b0; aluRelease = 1'b0;
    repeat (8) tick();
    chk("simul_pulse_count", 64'(pulses - p0), 64'(2));
    chk("simul_b_back_to_back", 64'(last_pulse_cyc), 64'(n_a + 5));
    push(ADDI);
    repeat (6) tick();
    chk("simul_credit_exhausted_stall", 64'(stall), 64'(1));
    chk("simul_no_extra_issue", 64'(pulses - p0), 64'(2));
    drain();

    // Release at full credit raises a sticky error that flush does not clear.
    chk("error_before", 64'(creditError), 64'(0));
    aluRelease = 1'b1;
    tick();
    aluRelease = 1'b0;
    chk("error_set", 64'(creditError), 64'(1));
    repeat (4) tick();
    do_flush();
    chk("error_sticky", 64'(creditError), 64'(1));

    // Flush while a strobe is high with three instructions still queued.
    make_rob_empty();
    for (int i = 0; i < QD; i++) push(ADDI);
    p0 = pulses;
    rel(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("flush_in_pulse", 64'(decodePulse), 64'(1));
    do_flush();
    chk("flush_decodePulse", 64'(decodePulse), 64'(0));
    chk("flush_available", 64'(available), 64'(0));
    chk("flush_fifo_empty", 64'(fetchReady), 64'(1));
    chk("flush_stall", 64'(stall), 64'(0));
    repeat (10) tick();
    chk("flush_no_more_pulses", 64'(pulses - p0), 64'(1));
    p1 = pulses;
    push(JAL);
    push(BEQ);
    repeat (10) tick();
    chk("flush_credits_restored", 64'(pulses - p1), 64'(2));
    push(JAL);
    repeat (8) tick();
    chk("flush_br_budget", 64'(pulses - p1), 64'(2));
    chk("flush_br_stall", 64'(stall), 64'(1));
    drain();

    // Asynchronous reset in the middle of SETUP.
    push(ADDI);
    tick();
    chk("setup_available", 64'(available), 64'(1));
    #1 reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    clear_model();
    @(posedge clock);
    #1 reset = 1'b0;
    p0 = pulses;
    repeat (10) tick();
    chk("reset_no_pulse", 64'(pulses - p0), 64'(0));

    // Randomized traffic with legal releases and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      bit fl;
      logic [31:0] r;
      fl = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 10)];
        fetchValid = 1'b1; fetchInstr = r; fetchPC = $urandom;
        if (fetchReady && !fl) exp_q.push_back({r, fetchPC});
      end
      robRelease = (rob_out > 0) && ($urandom_range(0, 3) == 0);
      aluRelease = (outst[0] > 0) && ($urandom_range(0, 2) == 0);
      lsuRelease = (outst[1] > 0) && ($urandom_range(0, 2) == 0);
      brRelease  = (outst[2] > 0) && ($urandom_range(0, 2) == 0);
      if (!fl) begin
        if (robRelease) rob_out--;
        if (aluRelease) outst[0]--;
        if (lsuRelease) outst[1]--;
        if (brRelease)  outst[2]--;
      end
      flush = fl;
      tick();
      fetchValid = 1'b0; flush = 1'b0;
      robRelease = 1'b0; aluRelease = 1'b0; lsuRelease = 1'b0; brRelease = 1'b0;
      if (fl) clear_model();
    end
    drain();
    chk("random_no_credit_error", 64'(creditError), 64'(0));
    chk("random_idle_available", 64'(available), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
